// File: rtl/processador_pkg.sv
// Shared definitions for the 16-bit multicycle processor: opcodes, ALU codes,
// FSM encoding and instruction field positions.
package processador_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_LI   = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int RD_HI   = 11;
  localparam int RD_LO   = 9;
  localparam int RS_HI   = 8;
  localparam int RS_LO   = 6;
  localparam int RT_HI   = 5;
  localparam int RT_LO   = 3;
  localparam int IMM6_HI = 5;
  localparam int IMM9_HI = 8;

  typedef enum logic [2:0] {
    ST_RST    = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } estado_t;

  function automatic logic eh_tipo_r(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  // Address arithmetic always adds; BEQ compares by subtracting.
  function automatic logic [2:0] alu_op_de(input logic [3:0] op);
    logic [2:0] r;
    case (op)
      OP_ADD:  r = ALU_ADD;
      OP_SUB:  r = ALU_SUB;
      OP_AND:  r = ALU_AND;
      OP_OR:   r = ALU_OR;
      OP_BEQ:  r = ALU_SUB;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/extensor_sinal.sv
// Immediate generator: LI uses the 9-bit field, every other opcode the
// 6-bit field, both sign-extended to 16 bits.
module extensor_sinal
  import processador_pkg::*;
(
  input  logic [15:0] instrucao,
  output logic [15:0] imediato
);

  // select and sign-extend the immediate field
  always_comb begin
    imediato = 16'h0000;
    if (instrucao[OPC_HI:OPC_LO] == OP_LI) begin
      imediato = {{7{instrucao[IMM9_HI]}}, instrucao[IMM9_HI:0]};
    end else begin
      imediato = {{10{instrucao[IMM6_HI]}}, instrucao[IMM6_HI:0]};
    end
  end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle control unit: owns PC/IR/ALUOut/MDR, fetches over a ready/request
// handshake and sequences the register bank and external ALU.
module unidade_controle
  import processador_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        MemReady,
  input  logic [15:0] MemDataIn,
  output logic        MemReq,
  output logic        MemWrite,
  output logic [15:0] MemAddr,
  output logic [15:0] MemDataOut,
  output logic [2:0]  Read1,
  output logic [2:0]  Read2,
  input  logic [15:0] Data1,
  input  logic [15:0] Data2,
  output logic [2:0]  WriteReg,
  output logic [15:0] WriteData,
  output logic        RegWrite,
  output logic [2:0]  AluOp,
  output logic        AluSrc,
  output logic [15:0] Imm,
  input  logic [15:0] AluResult,
  input  logic        AluZero,
  output logic        Halted
);

  estado_t     state_r, state_s;
  logic [15:0] pc_r, ir_r, aluout_r, mdr_r;
  logic [15:0] imm_s;
  logic [3:0]  opcode_s;
  logic        is_rtype_s;
  logic        unused_data1_s;

  assign opcode_s   = ir_r[OPC_HI:OPC_LO];
  assign is_rtype_s = eh_tipo_r(opcode_s);
  // Operand A goes straight from the bank to the ALU; the unit never looks at it.
  assign unused_data1_s = ^Data1;

  extensor_sinal u_extensor (
    .instrucao (ir_r),
    .imediato  (imm_s)
  );

  // state register and datapath registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_r  <= ST_RST;
      pc_r     <= RESET_PC;
      ir_r     <= 16'h0000;
      aluout_r <= 16'h0000;
      mdr_r    <= 16'h0000;
    end else begin
      state_r <= state_s;
      case (state_r)
        ST_FETCH: begin
          if (MemReady) begin
            ir_r <= MemDataIn;
            pc_r <= pc_r + 16'h0001;
          end
        end
        ST_EXEC: begin
          aluout_r <= AluResult;
          // PC already points past the branch, so the offset is relative to PC+1
          if ((opcode_s == OP_BEQ) && AluZero) begin
            pc_r <= pc_r + imm_s;
          end
        end
        ST_MEM: begin
          if (MemReady && (opcode_s == OP_LW)) begin
            mdr_r <= MemDataIn;
          end
        end
        default: ;
      endcase
    end
  end

  // next-state and Moore outputs decoded from state and IR
  always_comb begin
    state_s    = state_r;
    MemReq     = 1'b0;
    MemWrite   = 1'b0;
    MemAddr    = 16'h0000;
    MemDataOut = 16'h0000;
    Read1      = 3'd0;
    Read2      = 3'd0;
    WriteReg   = 3'd0;
    WriteData  = 16'h0000;
    RegWrite   = 1'b0;
    AluOp      = ALU_ADD;
    AluSrc     = 1'b0;
    Imm        = 16'h0000;
    Halted     = 1'b0;

    if (state_r != ST_RST) begin
      Read1    = ir_r[RS_HI:RS_LO];
      WriteReg = ir_r[RD_HI:RD_LO];
      Imm      = imm_s;
      AluOp    = alu_op_de(opcode_s);
      AluSrc   = (opcode_s == OP_ADDI) || (opcode_s == OP_LW) || (opcode_s == OP_SW);
      if ((opcode_s == OP_SW) || (opcode_s == OP_BEQ)) begin
        Read2 = ir_r[RD_HI:RD_LO];
      end else begin
        Read2 = ir_r[RT_HI:RT_LO];
      end
    end else begin
      Read1 = 3'd0;
    end

    case (state_r)
      ST_RST: state_s = ST_FETCH;
      ST_FETCH: begin
        MemReq  = 1'b1;
        MemAddr = pc_r;
        if (MemReady) begin
          state_s = ST_DECODE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_DECODE: state_s = ST_EXEC;
      ST_EXEC: begin
        if (is_rtype_s || (opcode_s == OP_ADDI) || (opcode_s == OP_LI)) begin
          state_s = ST_WB;
        end else if ((opcode_s == OP_LW) || (opcode_s == OP_SW)) begin
          state_s = ST_MEM;
        end else if (opcode_s == OP_HALT) begin
          state_s = ST_HALT;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_MEM: begin
        MemReq   = 1'b1;
        MemAddr  = aluout_r;
        MemWrite = (opcode_s == OP_SW);
        if (opcode_s == OP_SW) begin
          MemDataOut = Data2;
        end else begin
          MemDataOut = 16'h0000;
        end
        if (!MemReady) begin
          state_s = ST_MEM;
        end else if (opcode_s == OP_SW) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_WB;
        end
      end
      ST_WB: begin
        RegWrite = 1'b1;
        if (opcode_s == OP_LW) begin
          WriteData = mdr_r;
        end else if (opcode_s == OP_LI) begin
          WriteData = imm_s;
        end else begin
          WriteData = aluout_r;
        end
        state_s = ST_FETCH;
      end
      ST_HALT: begin
        Halted  = 1'b1;
        state_s = ST_HALT;
      end
      default: state_s = ST_RST;
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Directed bench for unidade_controle with a behavioural memory, register
// bank and ALU around the control unit.
module tb_unidade_controle;

  logic        clock = 1'b0;
  logic        resetn;
  logic        MemReady = 1'b0;
  logic [15:0] MemDataIn = 16'h0000;
  logic        MemReq, MemWrite, RegWrite, AluSrc, AluZero, Halted;
  logic [15:0] MemAddr, MemDataOut, Data1, Data2, WriteData, Imm, AluResult;
  logic [2:0]  Read1, Read2, WriteReg, AluOp;

  logic [15:0] mem [0:65535];
  logic [15:0] regs [0:7];
  logic        bank_clr;
  logic [15:0] alu_b;
  int          data_wait = 0;
  int          wait_cnt = 0;
  int          wr_cnt = 0;
  int          rw_count = 0;
  logic [15:0] wr_addr = 16'h0000;
  logic [15:0] wr_data = 16'h0000;
  int          checks = 0;
  int          errors = 0;

  unidade_controle #(.RESET_PC(16'h0000)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .MemReady   (MemReady),
    .MemDataIn  (MemDataIn),
    .MemReq     (MemReq),
    .MemWrite   (MemWrite),
    .MemAddr    (MemAddr),
    .MemDataOut (MemDataOut),
    .Read1      (Read1),
    .Read2      (Read2),
    .Data1      (Data1),
    .Data2      (Data2),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .RegWrite   (RegWrite),
    .AluOp      (AluOp),
    .AluSrc     (AluSrc),
    .Imm        (Imm),
    .AluResult  (AluResult),
    .AluZero    (AluZero),
    .Halted     (Halted)
  );

  always #5 clock = ~clock;

  assign Data1   = regs[Read1];
  assign Data2   = regs[Read2];
  assign AluZero = (AluResult == 16'h0000);

  // external ALU
  always_comb begin
    alu_b = AluSrc ? Imm : Data2;
    case (AluOp)
      3'd0:    AluResult = Data1 + alu_b;
      3'd1:    AluResult = Data1 - alu_b;
      3'd2:    AluResult = Data1 & alu_b;
      3'd3:    AluResult = Data1 | alu_b;
      default: AluResult = 16'h0000;
    endcase
  end

  // register bank, write commits at the edge that ends WB
  always @(posedge clock) begin
    if (bank_clr) begin
      for (int i = 0; i < 8; i++) regs[3'(i)] <= 16'h0000;
    end else if (RegWrite) begin
      regs[WriteReg] <= WriteData;
      rw_count <= rw_count + 1;
    end
  end

  // memory: 0x0080-0x00FF is the data region and inserts data_wait stalls;
  // MemReady is driven high while idle to show it is ignored then
  always @(negedge clock) begin
    if (MemReq) begin
      if ((MemAddr[15:7] == 9'h001) && (wait_cnt < data_wait)) begin
        MemReady  = 1'b0;
        MemDataIn = 16'hDEAD;
        wait_cnt  = wait_cnt + 1;
      end else begin
        MemReady  = 1'b1;
        MemDataIn = MemWrite ? 16'hDEAD : mem[MemAddr];
        wait_cnt  = 0;
        if (MemWrite) begin
          wr_addr = MemAddr;
          wr_data = MemDataOut;
          wr_cnt  = wr_cnt + 1;
        end
      end
    end else begin
      MemReady  = 1'b1;
      MemDataIn = 16'hDEAD;
      wait_cnt  = 0;
    end
  end

  task automatic next_fetch(output logic [15:0] a, output int cyc);
    a   = 16'h0000;
    cyc = -1;
    for (int i = 1; i <= 64; i++) begin
      @(negedge clock);
      if (MemReq && !MemWrite && (MemAddr[15:7] != 9'h001)) begin
        a   = MemAddr;
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [80:0] v;
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if ({RegWrite, MemReq, Halted} !== 3'b000) begin
        errors++;
        $display("FAIL reset_hold: RegWrite/MemReq/Halted=%b expected 000", {RegWrite, MemReq, Halted});
      end
    end
    bank_clr = 1'b0;
    resetn   = 1'b1;
    #1;
    v = {MemReq, MemWrite, RegWrite, Halted, AluSrc, AluOp, Read1, Read2, WriteReg,
         MemAddr, MemDataOut, WriteData, Imm};
    checks++;
    if (v !== 81'h0) begin
      errors++;
      $display("FAIL rst_outputs: got %h expected all zero", v);
    end
    @(negedge clock);
    checks++;
    if (!(MemReq === 1'b1 && MemWrite === 1'b0 && MemAddr === 16'h0000)) begin
      errors++;
      $display("FAIL first_fetch: MemReq=%b MemAddr=%h expected 1/0000", MemReq, MemAddr);
    end
  endtask

  task automatic test_alu_seq;
    logic [15:0] a;
    int cyc, total, rw0;
    total = 0;
    for (int k = 1; k <= 3; k++) begin
      rw0 = rw_count;
      next_fetch(a, cyc);
      total += cyc;
      checks++;
      if (a !== 16'(k) || cyc != 4) begin
        errors++;
        $display("FAIL alu_fetch%0d: addr=%h cyc=%0d expected %h/4", k, a, cyc, 16'(k));
      end
      checks++;
      if (rw_count - rw0 != 1) begin
        errors++;
        $display("FAIL alu_regwrite%0d: pulses=%0d expected 1", k, rw_count - rw0);
      end
    end
    checks++;
    if (total != 12) begin
      errors++;
      $display("FAIL alu_total: cycles=%0d expected 12", total);
    end
    checks++;
    if ({regs[1], regs[2], regs[3]} !== {16'h0005, 16'hFFFD, 16'h0002}) begin
      errors++;
      $display("FAIL alu_regs: r1=%h r2=%h r3=%h expected 0005 FFFD 0002", regs[1], regs[2], regs[3]);
    end
  endtask

  task automatic test_lw_wait;
    logic [15:0] a;
    int cyc, rw0;
    logic stable;
    data_wait = 3;
    next_fetch(a, cyc);
    checks++;
    if (a !== 16'h0004 || cyc != 4) begin
      errors++;
      $display("FAIL li_r6: addr=%h cyc=%0d expected 0004/4", a, cyc);
    end
    rw0 = rw_count;
    repeat (2) @(negedge clock);
    stable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (!(MemReq === 1'b1 && MemWrite === 1'b0 && MemAddr === 16'h0083)) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      errors++;
      $display("FAIL lw_stall: request not held, now MemReq=%b MemAddr=%h expected 1/0083", MemReq, MemAddr);
    end
    @(negedge clock);
    checks++;
    if (!(RegWrite === 1'b1 && WriteReg === 3'd4 && WriteData === 16'hBEEF)) begin
      errors++;
      $display("FAIL lw_wb: RegWrite=%b WriteReg=%0d WriteData=%h expected 1/4/BEEF", RegWrite, WriteReg, WriteData);
    end
    next_fetch(a, cyc);
    checks++;
    if (a !== 16'h0005 || 7 + cyc != 8) begin
      errors++;
      $display("FAIL lw_latency: addr=%h cycles=%0d expected 0005/8", a, 7 + cyc);
    end
    checks++;
    if (regs[4] !== 16'hBEEF || rw_count - rw0 != 1) begin
      errors++;
      $display("FAIL lw_result: r4=%h writes=%0d expected BEEF/1", regs[4], rw_count - rw0);
    end
    data_wait = 0;
  endtask

  task automatic test_sw;
    logic [15:0] a;
    int cyc, rw0, w0;
    rw0 = rw_count;
    w0  = wr_cnt;
    next_fetch(a, cyc);
    checks++;
    if (a !== 16'h0006 || cyc != 4) begin
      errors++;
      $display("FAIL sw_latency: addr=%h cyc=%0d expected 0006/4", a, cyc);
    end
    checks++;
    if (wr_cnt - w0 != 1 || wr_addr !== 16'h0085 || wr_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL sw_store: n=%0d addr=%h data=%h expected 1/0085/BEEF", wr_cnt - w0, wr_addr, wr_data);
    end
    checks++;
    if (rw_count != rw0) begin
      errors++;
      $display("FAIL sw_regwrite: pulses=%0d expected 0", rw_count - rw0);
    end
  endtask

  task automatic test_beq_wrap;
    logic [15:0] a;
    int cyc;
    logic ok;
    next_fetch(a, cyc);
    checks++;
    if (a !== 16'h0007 || cyc != 3) begin
      errors++;
      $display("FAIL beq_not_taken: addr=%h cyc=%0d expected 0007/3", a, cyc);
    end
    ok = 1'b1;
    for (int i = 0; i < 9; i++) begin
      next_fetch(a, cyc);
      if (cyc != 3) ok = 1'b0;
    end
    checks++;
    if (ok !== 1'b1 || a !== 16'h0010) begin
      errors++;
      $display("FAIL nop_run: addr=%h latency_ok=%b expected 0010/1", a, ok);
    end
    next_fetch(a, cyc);
    checks++;
    if (a !== 16'h000F || cyc != 3) begin
      errors++;
      $display("FAIL beq_taken: addr=%h cyc=%0d expected 000F/3", a, cyc);
    end
    mem[16'h0010] = 16'h7020;
    mem[16'h0000] = 16'hF000;
    next_fetch(a, cyc);
    next_fetch(a, cyc);
    checks++;
    if (a !== 16'hFFF1 || cyc != 3) begin
      errors++;
      $display("FAIL beq_back_wrap: addr=%h cyc=%0d expected FFF1/3", a, cyc);
    end
    for (int i = 0; i < 14; i++) next_fetch(a, cyc);
    checks++;
    if (a !== 16'hFFFF) begin
      errors++;
      $display("FAIL reach_ffff: addr=%h expected FFFF", a);
    end
    next_fetch(a, cyc);
    checks++;
    if (a !== 16'h0000 || cyc != 3) begin
      errors++;
      $display("FAIL pc_wrap: addr=%h cyc=%0d expected 0000/3", a, cyc);
    end
  endtask

  task automatic test_halt;
    logic quiet;
    repeat (3) @(negedge clock);
    checks++;
    if (Halted !== 1'b1 || MemReq !== 1'b0) begin
      errors++;
      $display("FAIL halt_enter: Halted=%b MemReq=%b expected 1/0", Halted, MemReq);
    end
    quiet = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (MemReq !== 1'b0 || Halted !== 1'b1) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL halt_hold: quiet=%b expected 1", quiet);
    end
  endtask

  task automatic test_reset_mid_mem;
    logic [15:0] a;
    int cyc, rw0;
    mem[16'h0000] = 16'h5983;
    mem[16'h0083] = 16'h1234;
    data_wait = 5;
    resetn = 1'b0;
    @(negedge clock);
    checks++;
    if (Halted !== 1'b0 || MemReq !== 1'b0) begin
      errors++;
      $display("FAIL halt_exit: Halted=%b MemReq=%b expected 0/0", Halted, MemReq);
    end
    resetn = 1'b1;
    @(negedge clock);
    repeat (3) @(negedge clock);
    checks++;
    if (!(MemReq === 1'b1 && MemAddr === 16'h0083)) begin
      errors++;
      $display("FAIL mid_mem_reach: MemReq=%b MemAddr=%h expected 1/0083", MemReq, MemAddr);
    end
    rw0 = rw_count;
    resetn = 1'b0;
    @(negedge clock);
    checks++;
    if ({MemReq, RegWrite, Halted} !== 3'b000 || MemAddr !== 16'h0000) begin
      errors++;
      $display("FAIL mid_mem_reset: MemReq/RegWrite/Halted=%b MemAddr=%h expected 000/0000",
               {MemReq, RegWrite, Halted}, MemAddr);
    end
    data_wait = 0;
    resetn = 1'b1;
    @(negedge clock);
    checks++;
    if (!(MemReq === 1'b1 && MemAddr === 16'h0000) || regs[4] !== 16'hBEEF || rw_count != rw0) begin
      errors++;
      $display("FAIL refetch: MemReq=%b MemAddr=%h r4=%h expected 1/0000/BEEF", MemReq, MemAddr, regs[4]);
    end
    next_fetch(a, cyc);
    checks++;
    if (a !== 16'h0001 || cyc != 5 || regs[4] !== 16'h1234) begin
      errors++;
      $display("FAIL lw_zero_wait: addr=%h cyc=%0d r4=%h expected 0001/5/1234", a, cyc, regs[4]);
    end
  endtask

  initial begin
    resetn   = 1'b0;
    bank_clr = 1'b1;
    for (int i = 0; i < 65536; i++) mem[16'(i)] = 16'h9000;
    mem[16'h0000] = 16'h8205;  // LI r1, 5
    mem[16'h0001] = 16'h85FD;  // LI r2, -3
    mem[16'h0002] = 16'h0650;  // ADD r3, r1, r2
    mem[16'h0003] = 16'h8C80;  // LI r6, 0x80
    mem[16'h0004] = 16'h5983;  // LW r4, 3(r6)
    mem[16'h0005] = 16'h6985;  // SW r4, 5(r6)
    mem[16'h0006] = 16'h7285;  // BEQ r1, r2, +5 (not taken)
    mem[16'h0010] = 16'h727E;  // BEQ r1, r1, -2
    mem[16'h0083] = 16'hBEEF;

    test_reset();
    test_alu_seq();
    test_lw_wait();
    test_sw();
    test_beq_wrap();
    test_halt();
    test_reset_mid_mem();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multicycle control unit for the 16-bit processor. It owns the PC and instruction register and fetches over a ready/request memory handshake. It sequences the 8×16 register bank through Read1/Read2/WriteReg/WriteData/RegWrite and drives the external ALU. Each instruction runs through a fixed-state FSM; the unit stops in HALT on the halt opcode.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value after reset.

Ports:
- clock  in  1  single system clock, rising edge.
- resetn  in  1  synchronous reset, active-low.
- MemReady  in  1  memory completes the current request on this cycle.
- MemDataIn  in  16  memory read data, valid with MemReady.
- MemReq  out  1  memory request.
- MemWrite  out  1  write qualifier for MemReq.
- MemAddr  out  16  word address.
- MemDataOut  out  16  store data (= Data2).
- Read1, Read2  out  3  register bank read indices.
- Data1, Data2  in  16  register bank read data (combinational).
- WriteReg  out  3  register bank write index.
- WriteData  out  16  register bank write data.
- RegWrite  out  1  register bank write enable.
- AluOp  out  3  ALU operation: 0 ADD, 1 SUB, 2 AND, 3 OR.
- AluSrc  out  1  ALU B operand: 0 = Data2, 1 = Imm.
- Imm  out  16  sign-extended immediate.
- AluResult  in  16  ALU output (A = Data1).
- AluZero  in  1  AluResult == 0.
- Halted  out  1  high in HALT.

## Operation
Instruction fields:
- [15:12] opcode, [11:9] rd, [8:6] rs, [5:3] rt.
- imm6 = [5:0] and imm9 = [8:0], both sign-extended to 16 bits.

Opcodes:
- 0–3: R-type. rd ← rs op rt; AluOp = opcode[1:0].
- 4: ADDI. rd ← rs + imm6.
- 5: LW. rd ← mem[rs + imm6].
- 6: SW. mem[rs + imm6] ← rd.
- 7: BEQ. If rd == rs, PC ← PC + imm6. PC has already been incremented.
- 8: LI. rd ← imm9.
- F: HALT.
- All others: NOP.

Register read index mapping:
- Read1 = rs.
- Read2 = rt for R-type; rd for SW and BEQ.
- WriteReg = rd.

FSM states: RST, FETCH, DECODE, EXEC, MEM, WB, HALT.
- RST: all outputs 0 → FETCH.
- FETCH: MemReq=1, MemAddr=PC. On MemReady, IR ← MemDataIn, PC ← PC+1 → DECODE. Otherwise hold.
- DECODE: bank read settles → EXEC.
- EXEC: ALUOut ← AluResult.
  - R-type, ADDI, LI → WB.
  - LW, SW → MEM.
  - BEQ: if AluZero (SUB), PC ← PC + Imm; → FETCH.
  - NOP → FETCH.
  - HALT → HALT.
- MEM: MemReq=1, MemAddr=ALUOut, MemWrite=(SW), MemDataOut=Data2. On MemReady: LW → MDR ← MemDataIn, → WB; SW → FETCH.
- WB: RegWrite=1 for exactly one cycle → FETCH. WriteData source:
  - ALUOut for R-type and ADDI.
  - MDR for LW.
  - Imm for LI.
- HALT: Halted=1, no requests. Left only by reset.

Rules:
- Arithmetic is mod 2^16; PC wraps from FFFF to 0000, and branch targets wrap the same way.
- r0 is an ordinary writable register.
- MemReady is ignored while MemReq=0.
- MemAddr, MemWrite and MemDataOut stay stable from request until completion.

## Timing
Reset:
- Any rising edge with resetn=0 enters RST. This includes resets in the middle of FETCH or MEM; the pending request is abandoned.
- Reset values: PC=RESET_PC, IR=0. MemReq, MemWrite, RegWrite, Halted = 0; all other outputs 0.
- The first FETCH (MemReq=1, MemAddr=RESET_PC) occurs on the second cycle after resetn rises.

Latency with zero-wait memory (MemReady tied high):
- R-type, ADDI, LI: 4 cycles.
- LW: 5 cycles.
- SW: 4 cycles.
- BEQ, NOP: 3 cycles.
- Each wait cycle in FETCH or MEM adds one cycle.

Other timing rules:
- A register write commits at the edge that ends WB, so the next instruction's DECODE sees the new value.
- Control outputs are Moore, decoded from state and IR; there is no combinational path from MemReady to MemReq.

## Structure
- Shared package processador_pkg holds:
  - opcode constants;
  - AluOp codes;
  - FSM state encoding;
  - instruction field bit positions.
- Sub-module extensor_sinal: imm6/imm9 sign extension selected by opcode.
- The FSM, PC, IR, ALUOut and MDR stay in unidade_controle.

## Test plan
- Reset: hold resetn=0 for 3 cycles, then release → RST, then FETCH with MemAddr=0000. RegWrite, MemReq and Halted are 0 during reset.
- LI r1,5; LI r2,−3; ADD r3,r1,r2 with zero-wait memory → r3=0002. RegWrite pulses exactly once per instruction; 12 cycles total.
- LW with MemReady low for 3 cycles in MEM → MemAddr/MemReq held stable; rd gets MemDataIn sampled on the ready cycle; latency 8 cycles.
- BEQ r1,r1,−2 at PC 0010 → next fetch address 000F. Also a not-taken BEQ → next fetch 0011. Also PC FFFF+1 wraps to 0000.
- SW r4 → mem[rs+imm] with MemWrite=1 and MemDataOut=r4 value; RegWrite stays 0.
- HALT → Halted=1 and no MemReq for 20 cycles. Reset asserted mid-MEM → RST on the next edge, then refetch from RESET_PC.
